pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the 2-bit IF_ID_Signal of the IF/ID pipeline register and enables or bubbles the PC and the later pipeline registers. It handles three cases:
- load-use stalls
- taken-branch flushes
- multi-cycle mult/div occupancy of the EX stage

It sits in the ID stage, beside the register file and control decoder.

Parameters:
REG_ADDR_W, 5, register-specifier width
MULDIV_LAT, 4, total EX cycles a mult/div instruction occupies (legal range 2..8)
CNT_W, 3, width of the mult/div stall down-counter (must hold MULDIV_LAT-2)

Ports:
Clock  input  1  pipeline clock, rising edge
Reset  input  1  asynchronous, active-high
ID_Rs  input  REG_ADDR_W  source register of instruction in ID
ID_Rt  input  REG_ADDR_W  second source register of instruction in ID
ID_UsesRt  input  1  instruction in ID reads Rt
EX_MemRead  input  1  instruction in EX is a load
EX_Rt  input  REG_ADDR_W  destination of load in EX
EX_MulDiv  input  1  instruction in EX is mult/div (stays high while it is held)
EX_BranchTaken  input  1  branch/jump in EX resolved taken
IF_ID_Signal  output  2  0 = pass, 1 = stall, 2 = flush (3 never driven)
PCWrite  output  1  PC update enable
ID_EX_Bubble  output  1  load zeros into ID/EX control fields
ID_EX_Hold  output  1  ID/EX keeps contents
EX_MEM_Bubble  output  1  insert bubble into EX/MEM
Busy  output  1  FSM not in RUN

Behaviour:
- Clock is named Clock; Reset is asynchronous and active-high.
- FSM states: RUN, MULDIV, DONE. State and counter are registered; all outputs are combinational from state and inputs, valid before the Clock edge.
- Reset asserted: state = RUN, cnt = 0, IF_ID_Signal = 2, PCWrite = 0, ID_EX_Bubble = 1, ID_EX_Hold = 0, EX_MEM_Bubble = 1, Busy = 0.
- Load-use hazard (LU): EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt)).

RUN priority, highest first:
1. EX_BranchTaken:
   - IF_ID_Signal = 2, PCWrite = 1 (target loads), ID_EX_Bubble = 1.
   - LU and EX_MulDiv ignored; a simultaneous EX_MulDiv is a protocol violation and the branch wins.
2. EX_MulDiv:
   - IF_ID_Signal = 1, PCWrite = 0, ID_EX_Hold = 1, EX_MEM_Bubble = 1.
   - If MULDIV_LAT == 2, next = DONE; else next = MULDIV with cnt = MULDIV_LAT-3.
3. LU:
   - IF_ID_Signal = 1, PCWrite = 0, ID_EX_Bubble = 1, one cycle only; the hazard clears as the load advances.
4. Otherwise: IF_ID_Signal = 0, PCWrite = 1, all bubble/hold outputs = 0.

MULDIV state:
- Same outputs as RUN case 2. LU, EX_BranchTaken and EX_MulDiv are ignored.
- cnt == 0 -> next = DONE; else cnt decrements.

DONE state:
- Normal pass outputs; the held instruction leaves EX. EX_MulDiv is ignored for this cycle only, so no retrigger.
- LU is still honoured as in RUN case 3. Next = RUN.

Net effect: the hold is high for exactly MULDIV_LAT-1 consecutive cycles, starting in the cycle EX_MulDiv first rises. Back-to-back mult/div retriggers on the RUN cycle after DONE.

Other rules:
- Reset asserted mid-MULDIV: immediate return to RUN and cnt = 0; no residual stall after deassert.
- Busy = (state != RUN).

Optional Feature:
HAZARD_STATS_EN
- Defined: adds output ports StallCount[31:0] and FlushCount[31:0].
  - StallCount increments on every cycle with IF_ID_Signal == 1.
  - FlushCount increments on every cycle with IF_ID_Signal == 2 while Reset is low.
  - Both counters saturate at 32'hFFFFFFFF and clear on Reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - IF_ID_Signal encodings: IFID_PASS = 2'd0, IFID_STALL = 2'd1, IFID_FLUSH = 2'd2.
  - FSM state encoding: RUN = 2'd0, MULDIV = 2'd1, DONE = 2'd2.
- One natural sub-module: load_use_detector, a purely combinational LU compare shared with the forwarding unit.

Test Plan:
- Reset high, then release mid-sequence -> IF_ID_Signal = 2, PCWrite = 0 while Reset high; IF_ID_Signal = 0, PCWrite = 1 on the first cycle after release.
- EX_MemRead = 1, EX_Rt = 5, ID_Rs = 5 -> exactly one cycle of IF_ID_Signal = 1, PCWrite = 0, ID_EX_Bubble = 1. Repeat with EX_Rt = 0 -> no stall.
- EX_MulDiv high with MULDIV_LAT = 4 -> ID_EX_Hold high exactly 3 cycles, then one DONE cycle with pass outputs, then RUN.
- Back-to-back mult/div (EX_MulDiv high 4 cycles, then a new instruction with EX_MulDiv high) -> second hold of 3 cycles starts in the RUN cycle after DONE.
- EX_BranchTaken = 1 together with LU true -> IF_ID_Signal = 2, PCWrite = 1, ID_EX_Bubble = 1, no stall.
- Reset pulsed during MULDIV with cnt = 1 -> Busy = 0 immediately; after release, EX_MulDiv = 0 gives IF_ID_Signal = 0. With HAZARD_STATS_EN defined, StallCount = 0 after the reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: IF/ID register control
// codes and the controller FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    IFID_PASS  = 2'd0,
    IFID_STALL = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MULDIV = 2'd1,
    DONE   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard bus between the ID-stage pipeline logic (master) and the hazard
// controller (slave).
interface pipeline_hazard_controller_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] ID_Rs;
  logic [REG_ADDR_W-1:0] ID_Rt;
  logic                  ID_UsesRt;
  logic                  EX_MemRead;
  logic [REG_ADDR_W-1:0] EX_Rt;
  logic                  EX_MulDiv;
  logic                  EX_BranchTaken;
  logic [1:0]            IF_ID_Signal;
  logic                  PCWrite;
  logic                  ID_EX_Bubble;
  logic                  ID_EX_Hold;
  logic                  EX_MEM_Bubble;
  logic                  Busy;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt, EX_MulDiv, EX_BranchTaken,
    input  IF_ID_Signal, PCWrite, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble, Busy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt, EX_MulDiv, EX_BranchTaken,
    output IF_ID_Signal, PCWrite, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble, Busy
  );
endinterface

// File: rtl/load_use_detector.sv
// Combinational load-use compare: a load in EX writes a register the ID
// instruction reads. Register 0 never hazards.
module load_use_detector #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes and
// mult/div EX occupancy. Optional HAZARD_STATS_EN adds stall/flush counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                         Clock,
  input  logic                         Reset,
  pipeline_hazard_controller_if.slave  hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                  StallCount,
  output logic [31:0]                  FlushCount
`endif
);

  // Remaining MULDIV-state cycles after the triggering RUN cycle, minus one.
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((MULDIV_LAT > 2) ? (MULDIV_LAT - 3) : 0);

  hz_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             load_use;
  ifid_e            ifid;

  load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
    .ex_mem_read (hz.EX_MemRead),
    .ex_rt       (hz.EX_Rt),
    .id_rs       (hz.ID_Rs),
    .id_rt       (hz.ID_Rt),
    .id_uses_rt  (hz.ID_UsesRt),
    .load_use    (load_use)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (!hz.EX_BranchTaken && hz.EX_MulDiv) begin
          if (MULDIV_LAT == 2) begin
            state_nx = DONE;
          end else begin
            state_nx = MULDIV;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      MULDIV: begin
        if (cnt == '0) state_nx = DONE;
        else           cnt_nx   = cnt - 1'b1;
      end
      DONE:    state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    ifid             = IFID_PASS;
    hz.PCWrite       = 1'b1;
    hz.ID_EX_Bubble  = 1'b0;
    hz.ID_EX_Hold    = 1'b0;
    hz.EX_MEM_Bubble = 1'b0;
    if (Reset) begin
      // Outputs follow Reset combinationally so the pipe is flushed while held.
      ifid             = IFID_FLUSH;
      hz.PCWrite       = 1'b0;
      hz.ID_EX_Bubble  = 1'b1;
      hz.EX_MEM_Bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hz.EX_BranchTaken) begin
            ifid            = IFID_FLUSH;
            hz.ID_EX_Bubble = 1'b1;
          end else if (hz.EX_MulDiv) begin
            ifid             = IFID_STALL;
            hz.PCWrite       = 1'b0;
            hz.ID_EX_Hold    = 1'b1;
            hz.EX_MEM_Bubble = 1'b1;
          end else if (load_use) begin
            ifid            = IFID_STALL;
            hz.PCWrite      = 1'b0;
            hz.ID_EX_Bubble = 1'b1;
          end
        end
        MULDIV: begin
          ifid             = IFID_STALL;
          hz.PCWrite       = 1'b0;
          hz.ID_EX_Hold    = 1'b1;
          hz.EX_MEM_Bubble = 1'b1;
        end
        DONE: begin
          if (load_use) begin
            ifid            = IFID_STALL;
            hz.PCWrite      = 1'b0;
            hz.ID_EX_Bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hz.IF_ID_Signal = ifid;
  assign hz.Busy         = (state != RUN);

`ifdef HAZARD_STATS_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (ifid == IFID_STALL && StallCount != '1) StallCount <= StallCount + 1'b1;
      if (ifid == IFID_FLUSH && FlushCount != '1) FlushCount <= FlushCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios then
// randomized traffic against a cycle-count reference model.
module tb_pipeline_hazard_controller;

  localparam int unsigned RW  = 5;
  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 3;

  logic Clock = 1'b0;
  logic Reset;

  pipeline_hazard_controller_if #(.REG_ADDR_W(RW)) hz ();

`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount, FlushCount;
  int unsigned exp_stall, exp_flush;
`endif

  pipeline_hazard_controller #(
    .REG_ADDR_W (RW),
    .MULDIV_LAT (LAT),
    .CNT_W      (CW)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .hz    (hz)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount (StallCount),
    .FlushCount (FlushCount)
`endif
  );

  always #5 Clock = ~Clock;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;

  // Model: hold cycles still owed after the current one, and whether the
  // current cycle is the post-hold cycle where mult/div is ignored.
  int unsigned hold_left = 0;
  bit          ign       = 1'b0;
  int unsigned hold_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pk(input logic [1:0] s, input logic pc, input logic b,
                                    input logic h, input logic e, input logic busy);
    return {s, pc, b, h, e, busy};
  endfunction

  task automatic drive(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic uses,
                       input logic mr, input logic [RW-1:0] ert, input logic md,
                       input logic br);
    hz.ID_Rs = rs; hz.ID_Rt = rt; hz.ID_UsesRt = uses;
    hz.EX_MemRead = mr; hz.EX_Rt = ert; hz.EX_MulDiv = md; hz.EX_BranchTaken = br;
  endtask

  // Check one cycle against the model, then advance through the clock edge.
  task automatic cycle(input string tag);
    logic [6:0]  exp;
    logic        lu;
    int unsigned nh;
    bit          ni;
    #3;
    lu = hz.EX_MemRead && (hz.EX_Rt != 0) &&
         ((hz.EX_Rt == hz.ID_Rs) || (hz.ID_UsesRt && hz.EX_Rt == hz.ID_Rt));
    nh = hold_left;
    ni = 1'b0;
    if (Reset) begin
      exp = pk(2'd2, 0, 1, 0, 1, 0);
      nh  = 0;
    end else if (hold_left > 0) begin
      exp = pk(2'd1, 0, 0, 1, 1, 1);
      nh  = hold_left - 1;
      ni  = (hold_left == 1);
    end else if (ign) begin
      exp = lu ? pk(2'd1, 0, 1, 0, 0, 1) : pk(2'd0, 1, 0, 0, 0, 1);
    end else if (hz.EX_BranchTaken) begin
      exp = pk(2'd2, 1, 1, 0, 0, 0);
    end else if (hz.EX_MulDiv) begin
      exp = pk(2'd1, 0, 0, 1, 1, 0);
      nh  = LAT - 2;
      ni  = (LAT == 2);
    end else if (lu) begin
      exp = pk(2'd1, 0, 1, 0, 0, 0);
    end else begin
      exp = pk(2'd0, 1, 0, 0, 0, 0);
    end
    chk(tag, 32'({hz.IF_ID_Signal, hz.PCWrite, hz.ID_EX_Bubble, hz.ID_EX_Hold,
                  hz.EX_MEM_Bubble, hz.Busy}), 32'(exp));
    if (hz.ID_EX_Hold) hold_seen++;
`ifdef HAZARD_STATS_EN
    if (Reset) begin
      exp_stall = 0;
      exp_flush = 0;
      chk({tag, "_stallcnt"}, StallCount, 32'd0);
    end
`endif
    @(posedge Clock);
    #1;
`ifdef HAZARD_STATS_EN
    if (!Reset) begin
      if (exp[6:5] == 2'd1) exp_stall++;
      if (exp[6:5] == 2'd2) exp_flush++;
    end
`endif
    hold_left = nh;
    ign       = ni;
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge Clock);
    #1;
    cycle("reset_a");
    cycle("reset_b");
    Reset = 1'b0;
    cycle("release");

    drive(5, 7, 0, 1, 5, 0, 0);
    cycle("lu_stall");
    drive(5, 7, 0, 0, 9, 0, 0);
    cycle("lu_clear");
    drive(0, 7, 1, 1, 0, 0, 0);
    cycle("lu_r0");
    drive(3, 6, 1, 1, 6, 0, 0);
    cycle("lu_rt");

    hold_seen = 0;
    drive(1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle("muldiv");
    drive(1, 2, 0, 0, 0, 0, 0);
    cycle("muldiv_after");
    chk("muldiv_hold_len", hold_seen, LAT - 1);

    hold_seen = 0;
    drive(1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2 * LAT; i++) cycle("b2b");
    drive(1, 2, 0, 0, 0, 0, 0);
    cycle("b2b_after");
    chk("b2b_hold_len", hold_seen, 2 * (LAT - 1));

    drive(5, 7, 0, 1, 5, 0, 1);
    cycle("branch_lu");
    drive(5, 7, 0, 0, 0, 0, 0);
    cycle("branch_after");

    drive(1, 2, 0, 0, 0, 1, 0);
    cycle("md_trigger");
    Reset = 1'b1;
    #1;
    chk("busy_on_reset", 32'(hz.Busy), 32'd0);
    cycle("md_reset");
    Reset = 1'b0;
    drive(1, 2, 0, 0, 0, 0, 0);
    cycle("md_post_reset");

    for (int i = 0; i < 600; i++) begin
      drive(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), RW'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      Reset = ($urandom_range(0, 63) == 0);
      cycle("random");
    end
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * LAT; i++) cycle("drain");

`ifdef HAZARD_STATS_EN
    chk("stall_count", StallCount, exp_stall);
    chk("flush_count", FlushCount, exp_flush);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
